// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Result lands in a single tagged response slot one cycle after accept; the slot stalls both requesters while held.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_data1_i,
    input  logic [DATA_W-1:0] req0_data2_i,
    input  logic [3:0]        req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_data1_i,
    input  logic [DATA_W-1:0] req1_data2_i,
    input  logic [3:0]        req1_ctrl_i,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [3:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_err_o,
    output logic [CNT_W-1:0]  op_cnt_o
);

    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_err;
    logic [CNT_W-1:0]  r_op_cnt;
    logic              r_last_grant;

    logic w_slot_free;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;

    // A held response frees its slot in the same cycle it is consumed, so a new op can pass through without a bubble.
    assign w_slot_free = !r_rsp_valid || rsp_ready_i;

    assign w_grant0 = req0_valid_i && (!req1_valid_i || r_last_grant);
    assign w_grant1 = req1_valid_i && (!req0_valid_i || !r_last_grant);

    assign req0_ready_o = w_grant0 && w_slot_free;
    assign req1_ready_o = w_grant1 && w_slot_free;
    assign w_accept     = req0_ready_o || req1_ready_o;

    always_comb begin
        alu_data1_o = '0;
        alu_data2_o = '0;
        alu_ctrl_o  = 4'b0010;
        if (w_grant0) begin
            alu_data1_o = req0_data1_i;
            alu_data2_o = req0_data2_i;
            alu_ctrl_o  = req0_ctrl_i;
        end else if (w_grant1) begin
            alu_data1_o = req1_data1_i;
            alu_data2_o = req1_data2_i;
            alu_ctrl_o  = req1_ctrl_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_op_cnt     <= '0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= req1_ready_o;
            r_last_grant <= req1_ready_o;
            r_op_cnt     <= r_op_cnt + CNT_W'(1);
            // Codes with bit 3 set are unsupported: respond with an error and a zero result.
            if (alu_ctrl_o[3]) begin
                r_rsp_result <= '0;
                r_rsp_err    <= 1'b1;
            end else begin
                r_rsp_result <= alu_result_i;
                r_rsp_err    <= 1'b0;
            end
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_id_o     = r_rsp_id;
    assign rsp_result_o = r_rsp_result;
    assign rsp_err_o    = r_rsp_err;
    assign op_cnt_o     = r_op_cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        v0, v1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;
    logic        rsp_rdy;

    logic        rdy0, rdy1, rv, rid, rerr;
    logic [31:0] alu_a, alu_b, alu_r, rres;
    logic [3:0]  alu_c;
    logic [15:0] cnt;

    logic        rdy0_w, rdy1_w, rv_w, rid_w, rerr_w;
    logic [31:0] alu_a_w, alu_b_w, alu_r_w, rres_w;
    logic [3:0]  alu_c_w;
    logic [1:0]  cnt_w;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_valid, m_id, m_err, m_last;
    logic [31:0] m_result;
    logic [15:0] m_cnt;
    logic        m_acc0, m_acc1;
    logic        exp_rdy0, exp_rdy1;
    logic [31:0] exp_a, exp_b;
    logic [3:0]  exp_c;
    logic        obs_rdy0, obs_rdy1;
    logic [31:0] obs_a, obs_b;
    logic [3:0]  obs_c;

    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
        case (c[2:0])
            3'd0:    alu_f = x & y;
            3'd1:    alu_f = x | y;
            3'd2:    alu_f = x + y;
            3'd3:    alu_f = x ^ y;
            3'd4:    alu_f = x << y[4:0];
            3'd5:    alu_f = x * y;
            3'd6:    alu_f = x - y;
            default: alu_f = {31'd0, $signed(x) < $signed(y)};
        endcase
    endfunction

    assign alu_r   = alu_f(alu_a, alu_b, alu_c);
    assign alu_r_w = alu_f(alu_a_w, alu_b_w, alu_c_w);

    alu_share_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_data1_i(a0), .req0_data2_i(b0), .req0_ctrl_i(c0),
        .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_data1_i(a1), .req1_data2_i(b1), .req1_ctrl_i(c1),
        .alu_data1_o(alu_a), .alu_data2_o(alu_b), .alu_ctrl_o(alu_c), .alu_result_i(alu_r),
        .rsp_valid_o(rv), .rsp_ready_i(rsp_rdy), .rsp_id_o(rid), .rsp_result_o(rres),
        .rsp_err_o(rerr), .op_cnt_o(cnt)
    );

    alu_share_arbiter #(.DATA_W(32), .CNT_W(2)) dut_w (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0_w), .req0_data1_i(a0), .req0_data2_i(b0), .req0_ctrl_i(c0),
        .req1_valid_i(v1), .req1_ready_o(rdy1_w), .req1_data1_i(a1), .req1_data2_i(b1), .req1_ctrl_i(c1),
        .alu_data1_o(alu_a_w), .alu_data2_o(alu_b_w), .alu_ctrl_o(alu_c_w), .alu_result_i(alu_r_w),
        .rsp_valid_o(rv_w), .rsp_ready_i(rsp_rdy), .rsp_id_o(rid_w), .rsp_result_o(rres_w),
        .rsp_err_o(rerr_w), .op_cnt_o(cnt_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: inputs are already driven (posedge+1); sample mid-cycle, then advance the model past the edge.
    task automatic cycle();
        int  win;
        logic free;
        logic [3:0] wc;
        #3;
        free = !m_valid || rsp_rdy;
        if (v0 && v1)  win = m_last ? 0 : 1;
        else if (v0)   win = 0;
        else if (v1)   win = 1;
        else           win = -1;
        exp_rdy0 = (win == 0) && free;
        exp_rdy1 = (win == 1) && free;
        exp_a = (win == 0) ? a0 : (win == 1) ? a1 : 32'd0;
        exp_b = (win == 0) ? b0 : (win == 1) ? b1 : 32'd0;
        exp_c = (win == 0) ? c0 : (win == 1) ? c1 : 4'b0010;
        obs_rdy0 = rdy0; obs_rdy1 = rdy1;
        obs_a = alu_a; obs_b = alu_b; obs_c = alu_c;
        m_acc0 = exp_rdy0 && !rst;
        m_acc1 = exp_rdy1 && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_id = 0; m_result = 0; m_err = 0; m_cnt = 0; m_last = 1;
        end else if (m_acc0 || m_acc1) begin
            wc       = m_acc1 ? c1 : c0;
            m_valid  = 1;
            m_id     = m_acc1;
            m_last   = m_acc1;
            m_cnt    = m_cnt + 16'd1;
            m_err    = wc[3];
            m_result = wc[3] ? 32'd0 : (m_acc1 ? alu_f(a1, b1, c1) : alu_f(a0, b0, c0));
        end else if (rsp_rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        v0 = 1; v1 = 1; rsp_rdy = 0;
        do_reset();
        v0 = 0; v1 = 0;
        n_checks++;
        if ({rv, rid, rres, rerr, cnt} !== {1'b0, 1'b0, 32'd0, 1'b0, 16'd0}) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b id=%b res=%h err=%b cnt=%0d want all zero", rv, rid, rres, rerr, cnt);
        end
        n_checks++;
        if ({rv_w, cnt_w} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state_w: got v=%b cnt=%0d want 0 0", rv_w, cnt_w);
        end
    endtask

    task automatic test_single();
        v0 = 1; a0 = 5; b0 = 3; c0 = 4'b0010; v1 = 0; rsp_rdy = 1;
        cycle();
        v0 = 0;
        n_checks++;
        if ({obs_rdy0, obs_rdy1} !== 2'b10) begin
            n_errors++;
            $display("FAIL single_ready: got %b%b want 10", obs_rdy0, obs_rdy1);
        end
        n_checks++;
        if ({obs_a, obs_b, obs_c} !== {32'd5, 32'd3, 4'b0010}) begin
            n_errors++;
            $display("FAIL single_alu_drive: got %h %h %h want 5 3 2", obs_a, obs_b, obs_c);
        end
        n_checks++;
        if ({rv, rid, rres, rerr, cnt} !== {1'b1, 1'b0, 32'd8, 1'b0, 16'd1}) begin
            n_errors++;
            $display("FAIL single_rsp: got v=%b id=%b res=%0d err=%b cnt=%0d want 1 0 8 0 1", rv, rid, rres, rerr, cnt);
        end
        cycle();
        n_checks++;
        if ({rv, obs_a, obs_b, obs_c} !== {1'b0, 32'd0, 32'd0, 4'b0010}) begin
            n_errors++;
            $display("FAIL idle_drain: got v=%b alu=%h %h %h want 0 0 0 2", rv, obs_a, obs_b, obs_c);
        end
    endtask

    task automatic test_contention();
        do_reset();
        v0 = 1; a0 = 7; b0 = 2; c0 = 4'b0110;
        v1 = 1; a1 = 6; b1 = 3; c1 = 4'b0101;
        rsp_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if ({obs_rdy0, obs_rdy1} !== {i % 2 == 0, i % 2 == 1}) begin
                n_errors++;
                $display("FAIL contention_grant%0d: got %b%b want %b%b", i, obs_rdy0, obs_rdy1, i % 2 == 0, i % 2 == 1);
            end
            n_checks++;
            if ({rv, rid, rres} !== {1'b1, i % 2 == 1, (i % 2 == 0) ? 32'd5 : 32'd18}) begin
                n_errors++;
                $display("FAIL contention_rsp%0d: got v=%b id=%b res=%0d", i, rv, rid, rres);
            end
        end
        n_checks++;
        if (cnt !== 16'd4) begin
            n_errors++;
            $display("FAIL contention_cnt: got %0d want 4", cnt);
        end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_backpressure();
        do_reset();
        v0 = 1; a0 = 7; b0 = 2; c0 = 4'b0110;
        v1 = 1; a1 = 6; b1 = 3; c1 = 4'b0101;
        rsp_rdy = 1;
        cycle();
        rsp_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if ({obs_rdy0, obs_rdy1, rv, rid, rres, rerr} !== {2'b00, 1'b1, 1'b0, 32'd5, 1'b0}) begin
                n_errors++;
                $display("FAIL backpressure_hold%0d: got rdy=%b%b v=%b id=%b res=%0d", i, obs_rdy0, obs_rdy1, rv, rid, rres);
            end
        end
        rsp_rdy = 1;
        cycle();
        n_checks++;
        if ({obs_rdy0, obs_rdy1} !== 2'b01) begin
            n_errors++;
            $display("FAIL backpressure_release_grant: got %b%b want 01", obs_rdy0, obs_rdy1);
        end
        n_checks++;
        if ({rv, rid, rres, cnt} !== {1'b1, 1'b1, 32'd18, 16'd2}) begin
            n_errors++;
            $display("FAIL backpressure_passthru: got v=%b id=%b res=%0d cnt=%0d want 1 1 18 2", rv, rid, rres, cnt);
        end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_bad_opcode();
        logic [15:0] prev;
        prev = cnt;
        v0 = 0; v1 = 1; a1 = 32'hFFFF_FFFF; b1 = 1; c1 = 4'b1001; rsp_rdy = 1;
        cycle();
        v1 = 0;
        n_checks++;
        if ({rv, rid, rres, rerr, cnt} !== {1'b1, 1'b1, 32'd0, 1'b1, prev + 16'd1}) begin
            n_errors++;
            $display("FAIL bad_opcode: got v=%b id=%b res=%h err=%b cnt=%0d want 1 1 0 1 %0d", rv, rid, rres, rerr, cnt, prev + 16'd1);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] e;
        do_reset();
        v0 = 1; a0 = 1; b0 = 1; c0 = 4'b0010; v1 = 0; rsp_rdy = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            e = 2'(i + 1);
            n_checks++;
            if (cnt_w !== e) begin
                n_errors++;
                $display("FAIL wrap_cnt%0d: got %0d want %0d", i, cnt_w, e);
            end
        end
        v0 = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        v0 = 1; a0 = 9; b0 = 4; c0 = 4'b0000; v1 = 0; rsp_rdy = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        n_checks++;
        if ({rv, cnt} !== {1'b0, 16'd0}) begin
            n_errors++;
            $display("FAIL reset_mid: got v=%b cnt=%0d want 0 0", rv, cnt);
        end
        v1 = 1; a1 = 2; b1 = 2; c1 = 4'b0001;
        cycle();
        n_checks++;
        if ({obs_rdy0, obs_rdy1, rid} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_mid_first_grant: got rdy=%b%b id=%b want 10 0", obs_rdy0, obs_rdy1, rid);
        end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_random();
        do_reset();
        v0 = 0; v1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!v0 || m_acc0) begin
                v0 = 1'($urandom_range(0, 1));
                a0 = $urandom; b0 = $urandom; c0 = 4'($urandom_range(0, 15));
            end
            if (!v1 || m_acc1) begin
                v1 = 1'($urandom_range(0, 1));
                a1 = $urandom; b1 = $urandom; c1 = 4'($urandom_range(0, 15));
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
            cycle();
            n_checks++;
            if ({obs_rdy0, obs_rdy1, obs_a, obs_b, obs_c} !== {exp_rdy0, exp_rdy1, exp_a, exp_b, exp_c}) begin
                n_errors++;
                $display("FAIL rand_drive%0d: got rdy=%b%b alu=%h %h %h want rdy=%b%b alu=%h %h %h",
                         i, obs_rdy0, obs_rdy1, obs_a, obs_b, obs_c, exp_rdy0, exp_rdy1, exp_a, exp_b, exp_c);
            end
            n_checks++;
            if ({rv, rid, rres, rerr, cnt, cnt_w} !== {m_valid, m_id, m_result, m_err, m_cnt, m_cnt[1:0]}) begin
                n_errors++;
                $display("FAIL rand_rsp%0d: got v=%b id=%b res=%h err=%b cnt=%0d/%0d want v=%b id=%b res=%h err=%b cnt=%0d",
                         i, rv, rid, rres, rerr, cnt, cnt_w, m_valid, m_id, m_result, m_err, m_cnt);
            end
        end
    endtask

    initial begin
        rst = 1; v0 = 0; v1 = 0; rsp_rdy = 0;
        a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
        m_valid = 0; m_id = 0; m_result = 0; m_err = 0; m_cnt = 0; m_last = 1;
        m_acc0 = 0; m_acc1 = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_bad_opcode();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
